vga_sync_decoder: RTL and testbench

Receiver side of the VGA timing interface: samples HS/VS sync pulses (as produced by the VGA timing generator) and reconstructs pixel coordinates, visible-area flag, frame strobe and lock status. It is used as an on-chip timing monitor for the display path and as the scan-in front end for the frame checker. It sits in the 50 MHz domain alongside the timing generator, advancing one pixel per pix_en strobe.

---
 rtl/vga_sync_decoder.sv | 195 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA sync receiver: tracks HS/VS against predicted raster position and recovers
// pixel coordinates, visible-area flag, frame strobe and lock status.
module vga_sync_decoder #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_TOTAL   = 525
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pix_en,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        active,
  output logic        locked,
  output logic        frame_start,
  output logic        line_err,
  output logic        frame_err,
  output logic [15:0] frame_count
);

  localparam int unsigned CW  = 10;
  localparam int unsigned FCW = 16;

  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_POS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_LINE   = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_FALL_POS  = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_RISE_POS  = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_FALL_LINE = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_RISE_LINE = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_H_ACQ,
    ST_V_ACQ,
    ST_LOCKED
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   hc_q, hc_d, vc_q, vc_d;
  logic            hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [1:0]      hacq_q, hacq_d;
  logic [CW-1:0]   drawx_q, drawx_d, drawy_q, drawy_d;
  logic            active_q, active_d, locked_q, locked_d;
  logic            fstart_q, fstart_d, lerr_q, lerr_d, ferr_q, ferr_d;
  logic [FCW-1:0]  fcount_q, fcount_d;

  logic [CW-1:0]   hc_pred, vc_pred;
  logic            hs_fall, hs_rise, vs_fall, vs_rise;
  logic            at_hs_fall, at_hs_rise, at_vs_fall, at_vs_rise;
  logic            h_viol, v_viol, h_chk, v_chk;

  // Free-running raster prediction for the pixel about to be sampled
  always_comb begin
    hc_pred = (hc_q == H_LAST) ? '0 : hc_q + CW'(1);
    vc_pred = vc_q;
    if (hc_q == H_LAST) begin
      vc_pred = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
    end
  end

  assign hs_fall    = hs_prev_q & ~hs_in;
  assign hs_rise    = ~hs_prev_q & hs_in;
  assign vs_fall    = vs_prev_q & ~vs_in;
  assign vs_rise    = ~vs_prev_q & vs_in;

  assign at_hs_fall = (hc_pred == HS_FALL_POS);
  assign at_hs_rise = (hc_pred == HS_RISE_POS);
  assign at_vs_fall = (hc_pred == '0) && (vc_pred == VS_FALL_LINE);
  assign at_vs_rise = (hc_pred == '0) && (vc_pred == VS_RISE_LINE);

  // Misplaced edge, or sync still high where its falling edge belongs
  assign h_viol = (hs_fall & ~at_hs_fall) | (hs_rise & ~at_hs_rise) | (at_hs_fall & hs_in);
  assign v_viol = (vs_fall & ~at_vs_fall) | (vs_rise & ~at_vs_rise) | (at_vs_fall & vs_in);
  assign h_chk  = (state_q != ST_UNLOCKED);
  assign v_chk  = (state_q == ST_V_ACQ) || (state_q == ST_LOCKED);

  // Next-state, counter load and output decode
  always_comb begin
    state_d   = state_q;
    hc_d      = hc_q;
    vc_d      = vc_q;
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;
    hacq_d    = hacq_q;
    lerr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (pix_en) begin
      hs_prev_d = hs_in;
      vs_prev_d = vs_in;
      lerr_d    = h_chk & h_viol;
      ferr_d    = v_chk & v_viol;

      hc_d = hc_pred;
      vc_d = vc_pred;
      if (vs_fall) begin
        hc_d = '0;
        vc_d = VS_FALL_LINE;
      end else if (hs_fall) begin
        hc_d = HS_FALL_POS;
      end

      if (hs_fall && (hacq_q != 2'd2)) begin
        hacq_d = hacq_q + 2'd1;
      end

      case (state_q)
        ST_UNLOCKED: begin
          if (hs_fall) begin
            state_d = ST_H_ACQ;
            hacq_d  = 2'd1;
          end
        end
        ST_H_ACQ: begin
          if (vs_fall && (hacq_q == 2'd2)) state_d = ST_V_ACQ;
        end
        ST_V_ACQ: begin
          if (vs_fall) state_d = ST_LOCKED;
        end
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_UNLOCKED;
      endcase

      // Vertical loss keeps horizontal lock; horizontal loss drops everything
      if (ferr_d) begin
        state_d = ST_H_ACQ;
        hacq_d  = 2'd2;
      end
      if (lerr_d) begin
        state_d = ST_UNLOCKED;
        hacq_d  = 2'd0;
      end
    end

    locked_d = (state_d == ST_LOCKED);
    drawx_d  = locked_d ? hc_d : '0;
    drawy_d  = locked_d ? vc_d : '0;
    active_d = locked_d && (hc_d < H_VIS_POS) && (vc_d < V_VIS_LINE);
    fstart_d = pix_en && locked_d && (hc_d == '0) && (vc_d == '0);
    fcount_d = fcount_q + FCW'(fstart_d);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_UNLOCKED;
      hc_q      <= '0;
      vc_q      <= '0;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      hacq_q    <= '0;
      drawx_q   <= '0;
      drawy_q   <= '0;
      active_q  <= 1'b0;
      locked_q  <= 1'b0;
      fstart_q  <= 1'b0;
      lerr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      fcount_q  <= '0;
    end else begin
      state_q   <= state_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      hacq_q    <= hacq_d;
      drawx_q   <= drawx_d;
      drawy_q   <= drawy_d;
      active_q  <= active_d;
      locked_q  <= locked_d;
      fstart_q  <= fstart_d;
      lerr_q    <= lerr_d;
      ferr_q    <= ferr_d;
      fcount_q  <= fcount_d;
    end
  end

  assign DrawX       = drawx_q;
  assign DrawY       = drawy_q;
  assign active      = active_q;
  assign locked      = locked_q;
  assign frame_start = fstart_q;
  assign line_err    = lerr_q;
  assign frame_err   = ferr_q;
  assign frame_count = fcount_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced raster (32x20) driven by a
// small sync generator model with injectable timing faults.
module tb_vga_sync_decoder;

  localparam int HV = 16, HF = 4, HSW = 6, HT = 32;
  localparam int VV = 12, VF = 2, VSW = 2, VT = 20;
  localparam int HS_FALL = HV + HF;
  localparam int HS_RISE = HV + HF + HSW;
  localparam int VS_FALL = VV + VF;
  localparam int VS_RISE = VV + VF + VSW;
  localparam int FRAME_PX = HT * VT;

  logic        Clk, Reset, pix_en, hs_in, vs_in;
  logic [9:0]  DrawX, DrawY;
  logic        active, locked, frame_start, line_err, frame_err;
  logic [15:0] frame_count;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_TOTAL(VT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .hs_in(hs_in), .vs_in(vs_in),
    .DrawX(DrawX), .DrawY(DrawY), .active(active), .locked(locked),
    .frame_start(frame_start), .line_err(line_err), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    int hc;
    int vc;
    int x;
    int y;
    int act;
  } vec_t;

  vec_t tbl[7];

  int n_vec, n_bad;
  int g_hc, g_vc, g_frame;
  int cur_hc, cur_vc, cur_frame, n_px;
  int short_line, vs_lo, vs_hi;
  int n_le, n_fe, n_fs;
  logic obs_le, obs_fe, obs_fs;

  // Pulse counters: every pulse is one Clk wide, so one negedge per pulse
  always @(negedge Clk) begin
    if (line_err === 1'b1)    n_le++;
    if (frame_err === 1'b1)   n_fe++;
    if (frame_start === 1'b1) n_fs++;
  end

  function automatic logic gen_hs(input int hc, input int vc);
    int rise;
    rise = (vc == short_line) ? HS_RISE - 1 : HS_RISE;
    return !((hc >= HS_FALL) && (hc < rise));
  endfunction

  function automatic logic gen_vs(input int vc);
    return !((vc >= vs_lo) && (vc < vs_hi));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One strobed pixel followed by one idle Clk; adv=0 repeats the same pixel
  task automatic pixel(input bit adv);
    hs_in  = gen_hs(g_hc, g_vc);
    vs_in  = gen_vs(g_vc);
    pix_en = 1'b1;
    @(posedge Clk); #1;
    pix_en    = 1'b0;
    obs_le    = line_err;
    obs_fe    = frame_err;
    obs_fs    = frame_start;
    cur_hc    = g_hc;
    cur_vc    = g_vc;
    cur_frame = g_frame;
    n_px++;
    if (adv) begin
      if (g_hc == HT - 1) begin
        g_hc = 0;
        if (g_vc == VT - 1) begin
          g_vc = 0;
          g_frame++;
        end else begin
          g_vc++;
        end
      end else begin
        g_hc++;
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic run_to(input int hc, input int vc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME_PX; i++) begin
      pixel(1'b1);
      if (cur_hc == hc && cur_vc == vc) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_until_locked(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6 * FRAME_PX; i++) begin
      pixel(1'b1);
      if (locked === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_until_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FRAME_PX + 1; i++) begin
      pixel(1'b1);
      if (obs_fs === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_drawx"}, DrawX, 0);
    chk({tag, "_drawy"}, DrawY, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_fstart"}, frame_start, 0);
    chk({tag, "_lerr"}, line_err, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_fcount"}, frame_count, 0);
  endtask

  task automatic gen_restart();
    g_hc = 0; g_vc = 0; g_frame = 0;
    short_line = -1; vs_lo = VS_FALL; vs_hi = VS_RISE;
  endtask

  initial begin
    bit ok;
    int px0, le0, fe0, fs0, loss_frame;

    tbl[0] = '{hc: 5,      vc: 8,       x: 5,      y: 8,       act: 1};
    tbl[1] = '{hc: 25,     vc: 8,       x: 25,     y: 8,       act: 0};
    tbl[2] = '{hc: HV - 1, vc: VV - 1,  x: HV - 1, y: VV - 1,  act: 1};
    tbl[3] = '{hc: HV,     vc: VV - 1,  x: HV,     y: VV - 1,  act: 0};
    tbl[4] = '{hc: HV - 1, vc: VV,      x: HV - 1, y: VV,      act: 0};
    tbl[5] = '{hc: HS_FALL, vc: VS_FALL + 1, x: HS_FALL, y: VS_FALL + 1, act: 0};
    tbl[6] = '{hc: HT - 1, vc: VT - 1,  x: HT - 1, y: VT - 1,  act: 0};

    n_vec = 0; n_bad = 0; n_px = 0; n_le = 0; n_fe = 0; n_fs = 0;
    gen_restart();
    Clk = 1'b0; Reset = 1'b0; pix_en = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    #2 Reset = 1'b1;
    #3 chk_all_zero("rst");
    #40 Reset = 1'b0;
    @(posedge Clk); #1;

    // Acquisition from reset on ideal timing
    run_until_locked(ok);
    chk("lock1_reached", ok, 1);
    chk("lock1_frame", cur_frame, 1);
    chk("lock1_hc", cur_hc, 0);
    chk("lock1_vc", cur_vc, VS_FALL);
    chk("lock1_drawx", DrawX, 0);
    chk("lock1_drawy", DrawY, VS_FALL);
    chk("lock1_active", active, 0);
    chk("lock1_fcount", frame_count, 0);
    px0 = n_px;
    run_until_fs(ok);
    chk("fs1_reached", ok, 1);
    chk("fs1_distance", n_px - px0, (VT - VS_FALL) * HT);
    chk("fs1_drawx", DrawX, 0);
    chk("fs1_drawy", DrawY, 0);
    chk("fs1_active", active, 1);
    chk("fs1_fcount", frame_count, 1);

    for (int i = 0; i < 7; i++) begin
      run_to(tbl[i].hc, tbl[i].vc, ok);
      chk($sformatf("tbl%0d_reach", i), ok, 1);
      chk($sformatf("tbl%0d_drawx", i), DrawX, tbl[i].x);
      chk($sformatf("tbl%0d_drawy", i), DrawY, tbl[i].y);
      chk($sformatf("tbl%0d_active", i), active, tbl[i].act);
      chk($sformatf("tbl%0d_locked", i), locked, 1);
    end

    run_until_fs(ok);
    chk("fs2_reached", ok, 1);
    run_until_fs(ok);
    chk("fs3_reached", ok, 1);
    chk("fs3_fcount", frame_count, 3);
    chk("clean_line_errs", n_le, 0);
    chk("clean_frame_errs", n_fe, 0);
    chk("clean_fs_pulses", n_fs, 3);

    // Strobe held off mid-line with garbage on the sync inputs
    run_to(9, 4, ok);
    chk("frz_reach", ok, 1);
    le0 = n_le; fe0 = n_fe; fs0 = n_fs;
    hs_in = 1'b0; vs_in = 1'b0;
    repeat (100) @(posedge Clk);
    #1;
    chk("frz_drawx", DrawX, 9);
    chk("frz_drawy", DrawY, 4);
    chk("frz_active", active, 1);
    chk("frz_locked", locked, 1);
    chk("frz_fcount", frame_count, 3);
    chk("frz_pulses", (n_le - le0) + (n_fe - fe0) + (n_fs - fs0), 0);
    pixel(1'b1);
    chk("frz_resume_drawx", DrawX, 10);
    chk("frz_resume_lerr", obs_le, 0);

    // HS fall delayed by 4 pixels: pixel HS_FALL-1 sampled 5 times
    run_to(HS_FALL - 2, 7, ok);
    chk("hdly_reach", ok, 1);
    le0 = n_le;
    pixel(1'b0);
    chk("hdly_pre_lerr", obs_le, 0);
    pixel(1'b0);
    chk("hdly_lerr", obs_le, 1);
    chk("hdly_locked", locked, 0);
    chk("hdly_drawx", DrawX, 0);
    chk("hdly_drawy", DrawY, 0);
    chk("hdly_ferr", obs_fe, 0);
    pixel(1'b0);
    pixel(1'b0);
    pixel(1'b1);
    loss_frame = g_frame;
    run_until_locked(ok);
    chk("hdly_relock", ok, 1);
    chk("hdly_relock_frame", cur_frame, loss_frame + 1);
    chk("hdly_relock_vc", cur_vc, VS_FALL);
    chk("hdly_relock_drawy", DrawY, VS_FALL);
    chk("hdly_lerr_count", n_le - le0, 1);
    chk("hdly_fcount", frame_count, 3);

    // HS low one pixel short on a single line
    run_to(HS_RISE - 2, VT - 2, ok);
    chk("hshort_reach", ok, 1);
    short_line = VT - 2;
    pixel(1'b1);
    short_line = -1;
    chk("hshort_lerr", obs_le, 1);
    chk("hshort_locked", locked, 0);
    run_until_locked(ok);
    chk("hshort_relock", ok, 1);
    chk("hshort_relock_vc", cur_vc, VS_FALL);

    // VS falls one line late for one frame
    run_to(HT - 1, VS_FALL - 1, ok);
    chk("vlate_reach", ok, 1);
    le0 = n_le; fe0 = n_fe;
    vs_lo = VS_FALL + 1; vs_hi = VS_RISE + 1;
    pixel(1'b1);
    chk("vlate_ferr", obs_fe, 1);
    chk("vlate_lerr", obs_le, 0);
    chk("vlate_locked", locked, 0);
    chk("vlate_drawx", DrawX, 0);
    run_to(0, VS_RISE + 1, ok);
    chk("vlate_pass", ok, 1);
    vs_lo = VS_FALL; vs_hi = VS_RISE;
    run_until_locked(ok);
    chk("vlate_relock", ok, 1);
    chk("vlate_relock_hc", cur_hc, 0);
    chk("vlate_relock_vc", cur_vc, VS_FALL);
    chk("vlate_relock_drawy", DrawY, VS_FALL);
    chk("vlate_lerr_count", n_le - le0, 0);
    chk("vlate_ferr_count", n_fe - fe0, 2);

    // Asynchronous reset mid-frame, then reacquire from scratch
    run_to(9, 6, ok);
    chk("arst_reach", ok, 1);
    chk("arst_pre_fcount", frame_count, 5);
    chk("arst_pre_drawx", DrawX, 9);
    #4 Reset = 1'b1;
    #1 chk_all_zero("arst");
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    gen_restart();
    run_until_locked(ok);
    chk("lock2_reached", ok, 1);
    chk("lock2_frame", cur_frame, 1);
    chk("lock2_hc", cur_hc, 0);
    chk("lock2_vc", cur_vc, VS_FALL);
    chk("lock2_drawy", DrawY, VS_FALL);
    chk("lock2_fcount", frame_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
